tt_um_serial_addsub: RTL

TT_UM_SERIAL_ADDSUB -- requirements
Module: tt_um_serial_addsub

---
 rtl/tt_um_serial_addsub.sv | 120 ++++++++++++
 1 files changed

// File: rtl/tt_um_serial_addsub.sv
// Bit-serial adder/subtractor: operands are loaded a byte at a time, processed one bit per
// enabled cycle LSB first, and the result is read back a byte at a time.
module tt_um_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NB = WIDTH / 8;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_LOAD_A = 2'd0;
    localparam logic [1:0] OP_LOAD_B = 2'd1;
    localparam logic [1:0] OP_START  = 2'd2;
    localparam logic [1:0] OP_NEXT   = 2'd3;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg, b_reg, r_reg;
    logic             carry_reg, sub_reg, cout_reg, ovf_reg;
    logic [CW-1:0]    cnt_reg;
    logic [PW-1:0]    ptr_reg;

    logic             cmd, last_bit;
    logic             b_bit, s_bit, c_next;
    logic [WIDTH+7:0] a_cat, b_cat;
    logic             unused_bits;

    assign cmd         = ena & uio_in[3];
    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));
    assign unused_bits = ^uio_in[7:4];

    // Concatenate-then-drop keeps the byte shift legal even when WIDTH is a single byte.
    assign a_cat = {ui_in, a_reg};
    assign b_cat = {ui_in, b_reg};

    assign b_bit  = b_reg[0] ^ sub_reg;
    assign s_bit  = a_reg[0] ^ b_bit ^ carry_reg;
    assign c_next = (a_reg[0] & b_bit) | (a_reg[0] & carry_reg) | (b_bit & carry_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
        end else if (ena) begin
            case (state_reg)
                IDLE, DONE: begin
                    if (cmd) begin
                        case (uio_in[1:0])
                            OP_LOAD_A: begin
                                a_reg     <= a_cat[WIDTH+7:8];
                                state_reg <= IDLE;
                            end
                            OP_LOAD_B: begin
                                b_reg     <= b_cat[WIDTH+7:8];
                                state_reg <= IDLE;
                            end
                            OP_START: begin
                                sub_reg   <= uio_in[2];
                                carry_reg <= uio_in[2];
                                cnt_reg   <= '0;
                                ptr_reg   <= '0;
                                cout_reg  <= 1'b0;
                                ovf_reg   <= 1'b0;
                                state_reg <= RUN;
                            end
                            default: begin
                                if (state_reg == DONE)
                                    ptr_reg <= (ptr_reg == PW'(NB - 1)) ? '0 : ptr_reg + PW'(1);
                            end
                        endcase
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    r_reg     <= {s_bit, r_reg[WIDTH-1:1]};
                    carry_reg <= c_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        // On the MSB step the operand bits are the sign bits.
                        cout_reg  <= c_next;
                        ovf_reg   <= (a_reg[0] == b_bit) && (s_bit != a_reg[0]);
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [7:0] r_bytes [NB];
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
            assign r_bytes[gi] = r_reg[8*gi +: 8];
        end
    endgenerate

    assign uo_out  = (state_reg == DONE) ? r_bytes[ptr_reg] : 8'h00;
    assign uio_out = {ovf_reg, cout_reg, state_reg == DONE, state_reg == RUN, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule
